// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter between fetch and data paths with starvation guard and in-order read response routing
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LAT = 1,
  parameter int STARVE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic [DW-1:0]   mem_rdata
);
  localparam int CW = $clog2(STARVE + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE);
  typedef enum logic {DATA_PRI, FETCH_PRI} pri_t;
  pri_t pri;
  logic [CW-1:0] starve_cnt, cnt_nxt;
  logic [LAT-1:0] vld, fet;
  assign if_gnt = !rst && if_req && (pri == FETCH_PRI || !d_req);
  assign d_gnt = !rst && d_req && (pri == DATA_PRI || !if_req);
  assign cnt_nxt = (!if_req || if_gnt) ? '0 : (d_gnt && starve_cnt != SMAX) ? starve_cnt + 1'b1 : starve_cnt;
  assign mem_en = if_gnt || d_gnt;
  assign mem_we = d_gnt && d_we;
  assign mem_addr = d_gnt ? d_addr : if_gnt ? if_addr : '0;
  assign mem_wdata = d_gnt ? d_wdata : '0;
  assign mem_wstrb = d_gnt ? d_wstrb : '0;
  assign if_rvalid = !rst && vld[LAT-1] && fet[LAT-1];
  assign d_rvalid = !rst && vld[LAT-1] && !fet[LAT-1];
  assign if_rdata = if_rvalid ? mem_rdata : '0;
  assign d_rdata = d_rvalid ? mem_rdata : '0;
  // priority flips as the counter reaches STARVE so fetch wins on the very next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      pri <= DATA_PRI;
      starve_cnt <= '0;
      vld <= '0;
      fet <= '0;
    end else begin
      starve_cnt <= cnt_nxt;
      pri <= (pri == DATA_PRI) ? ((cnt_nxt == SMAX) ? FETCH_PRI : DATA_PRI) : ((if_gnt || !if_req) ? DATA_PRI : FETCH_PRI);
      vld[0] <= if_gnt || (d_gnt && !d_we);
      fet[0] <= if_gnt;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        fet[i] <= fet[i-1];
      end
    end
  end
endmodule
